// File: rtl/pipe_pkg.sv
// Shared types for the EX/MEM skid stage: state encoding, default widths,
// control-bit bundle and the default-width payload record.
package pipe_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_W_DEF  = 5;
    localparam int CNT_W_DEF  = 16;

    // EMPTY: nothing held, FULL: main entry only, SKID: main and skid entries
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } skid_state_e;

    // Control bits travelling with each instruction
    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic mem_write;
    } ctrl_t;

    // Payload record at default widths; the stage re-declares the same layout
    // with its own DATA_W/REG_W so the record follows the parameters.
    typedef struct packed {
        logic [DATA_W_DEF-1:0] alu_out;
        logic [DATA_W_DEF-1:0] write_data;
        logic [REG_W_DEF-1:0]  write_reg;
        ctrl_t                 ctrl;
    } payload_t;

    // A state holds a presentable entry whenever it is not EMPTY
    function automatic logic has_entry(input skid_state_e s);
        return s != EMPTY;
    endfunction

endpackage

// File: rtl/exmem_skid_stage_sat_counter.sv
// Saturating up-counter: counts cycles with inc high, sticks at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: step by one unless already saturated
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    // Counter register, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/exmem_skid_stage.sv
// EX/MEM pipeline register built as a two-entry skid buffer. ex_ready is a
// flop so no combinational path exists from mem_ready back to the EX side;
// the skid entry absorbs the one payload that arrives while ready catches up.
module exmem_skid_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_W  = REG_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [DATA_W-1:0] ex_alu_out,
    input  logic [DATA_W-1:0] ex_write_data,
    input  logic [REG_W-1:0]  ex_write_reg,
    input  logic              ex_reg_write,
    input  logic              ex_mem_to_reg,
    input  logic              ex_mem_write,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] mem_alu_out,
    output logic [DATA_W-1:0] mem_write_data,
    output logic [REG_W-1:0]  mem_write_reg,
    output logic              mem_reg_write,
    output logic              mem_mem_to_reg,
    output logic              mem_mem_write,
    output logic [CNT_W-1:0]  stall_cycles
);

    typedef struct packed {
        logic [DATA_W-1:0] alu_out;
        logic [DATA_W-1:0] write_data;
        logic [REG_W-1:0]  write_reg;
        ctrl_t             ctrl;
    } entry_t;

    skid_state_e state_q, state_d;
    entry_t      main_q, main_d;
    entry_t      skid_q, skid_d;
    logic        ex_ready_q, ex_ready_d;

    entry_t ex_entry;
    logic   in_xfer;
    logic   out_xfer;

    assign ex_entry = '{alu_out:    ex_alu_out,
                        write_data: ex_write_data,
                        write_reg:  ex_write_reg,
                        ctrl:       '{reg_write:  ex_reg_write,
                                      mem_to_reg: ex_mem_to_reg,
                                      mem_write:  ex_mem_write}};

    assign in_xfer  = ex_valid && ex_ready_q;
    assign out_xfer = mem_valid && mem_ready;

    // Next state and entry contents; flush wins over any handshake
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    main_d  = ex_entry;
                    state_d = FULL;
                end
            end
            FULL: begin
                if (in_xfer && out_xfer) begin
                    main_d = ex_entry;
                end else if (in_xfer) begin
                    skid_d  = ex_entry;
                    state_d = SKID;
                end else if (out_xfer) begin
                    state_d = EMPTY;
                end
            end
            SKID: begin
                // ex_ready is low here, so only the drain side can move
                if (out_xfer) begin
                    main_d  = skid_q;
                    state_d = FULL;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (flush) begin
            state_d = EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end
    end

    // Ready is computed from the next state so it is a pure flop output
    always_comb begin
        ex_ready_d = (state_d != SKID);
    end

    // State, entries and ready register, all cleared by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            ex_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            ex_ready_q <= ex_ready_d;
        end
    end

    assign ex_ready       = ex_ready_q;
    assign mem_valid      = has_entry(state_q);
    assign mem_alu_out    = main_q.alu_out;
    assign mem_write_data = main_q.write_data;
    assign mem_write_reg  = main_q.write_reg;
    // Main entry can hold stale bits after a drain; controls must read 0 then
    assign mem_reg_write  = mem_valid && main_q.ctrl.reg_write;
    assign mem_mem_to_reg = mem_valid && main_q.ctrl.mem_to_reg;
    assign mem_mem_write  = mem_valid && main_q.ctrl.mem_write;

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (mem_valid && !mem_ready),
        .count (stall_cycles)
    );

endmodule
